serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial subtractor computing Diff = A - B - bin, one bit per clock, LSB first, under a start/done handshake. It is the inverse-direction companion to the team's combinational 4-bit adder, and {bo,Diff} round-trips against that adder. It sits in the arithmetic datapath where area matters more than latency; the bench cross-checks it against the adder, i.e. A == adder(Diff, B, bin) when bo=0.

Parameters:
WIDTH, 4, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; samples A, B and bin when the block is idle
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
bin  input  1  borrow-in
Diff  output  WIDTH  registered difference, held until the next completion
bo  output  1  registered borrow-out: 1 when A < B + bin (unsigned)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when Diff/bo update

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. While rst_n=0: state=IDLE, Diff=0, bo=0, busy=0, done=0, and all internal shift/counter registers are 0.
- FSM has two states: IDLE and RUN.
- IDLE with start=1 on edge k:
  - load a_sh=A, b_sh=B, br=bin, cnt=0;
  - go to RUN with busy=1.
- IDLE with start=0: hold state; done=0.
- RUN, each edge:
  - d = a_sh[0]^b_sh[0]^br;
  - br <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br);
  - shift a_sh and b_sh right by 1;
  - shift d into the MSB of d_sh;
  - cnt <= cnt+1.
- RUN with cnt==WIDTH-1, on edge k+WIDTH:
  - Diff <= {d, d_sh[WIDTH-1:1]};
  - bo <= next borrow;
  - done <= 1 for exactly one cycle;
  - busy <= 0;
  - state <= IDLE.
- Latency: done is high in the cycle after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- Arithmetic: the result is A - B - bin mod 2^WIDTH. The identity {bo,Diff} == (2^WIDTH + A - B - bin) with bo inverted holds; equivalently, A - B - bin == Diff - bo*2^WIDTH.
- Boundary conditions:
  - start while busy: ignored; operands are not resampled and the operation is not restarted.
  - start in the same cycle done=1: accepted, because the state is IDLE; back-to-back throughput is one result per WIDTH+1 cycles.
  - A/B/bin changing during RUN: no effect on the result.
  - Diff/bo: never change except on a done edge or on reset. Outputs are not X after reset.
  - Reset mid-operation: abort immediately; outputs return to their reset values; done is not pulsed.
  - Wrap-around: 0-1 gives Diff=all ones, bo=1. 0-0-1 gives Diff=all ones, bo=1. (2^WIDTH-1)-0-0 gives Diff=all ones, bo=0.
  - cnt width: clog2(WIDTH); it never exceeds WIDTH-1.

Decomposition:
- Shared package arith_pkg:
  - state enum {IDLE, RUN};
  - constant DEFAULT_WIDTH=4;
  - function clog2 for the counter width.
- One sub-module, full_subtractor: combinational 1-bit cell with ports a, b, bin, d, bout, instantiated once for the serial step.
- The FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> Diff=0, bo=0, busy=0, done=0; no operation starts until rst_n=1.
- Basic: A=9, B=3, bin=0, start pulse -> busy high for 4 cycles, then done pulses once with Diff=6, bo=0.
- Borrow/wrap: A=5, B=7, bin=0 -> Diff=14, bo=1. A=0, B=0, bin=1 -> Diff=15, bo=1. A=15, B=15, bin=1 -> Diff=15, bo=1.
- Handshake:
  - start held high continuously with A=8, B=1 -> results every 5 cycles, Diff=7;
  - change A to 2 mid-RUN -> the in-flight result is still 7.
- Reset mid-op: assert rst_n=0 two cycles after start -> busy/done/Diff/bo go to 0 asynchronously; after release, a new start of A=4, B=4 gives Diff=0, bo=0.
- Exhaustive: all bin in {0,1}, A in 0..15, B in 0..15 -> each done gives A-B-bin == Diff-16*bo. When bo=0, the adder model gives Diff+B+bin == A. Stop on the first mismatch; print SUCCESS otherwise.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding, default width and
// a constant-evaluable clog2 helper.
package arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Clamped to 1 so that a counter built from it is never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - bin, one bit per clock, LSB first,
// with a start/busy/done handshake. One result per WIDTH+1 cycles back-to-back.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] Diff,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             done_q, done_d;

  logic d_bit, br_nxt, last;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_nxt)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Operands are sampled only here, so start/A/B/bin are don't-care in RUN.
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        d_sh_d = {d_bit, d_sh_q[WIDTH-1:1]};
        br_d   = br_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          diff_d  = {d_bit, d_sh_q[WIDTH-1:1]};
          bo_d    = br_nxt;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
    end
  end

  assign Diff = diff_q;
  assign bo   = bo_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a monitor pops and checks them on every done pulse.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk, rst_n, start, bin;
  logic [W-1:0] A, B, Diff;
  logic         bo, busy, done;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .Diff  (Diff),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Independent 4-bit adder model: returns {cout, sum}.
  function automatic logic [W:0] adder(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Monitor: compares on done, otherwise Diff/bo must hold.
  logic [W-1:0] prev_d;
  logic         prev_bo;
  always @(posedge clk) begin
    exp_t e;
    int   lhs, rhs;
    logic [W:0] s;
    #1;
    if (!rst_n) begin
      prev_d  = Diff;
      prev_bo = bo;
    end else if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Diff=%0d bo=%0d with no pending request", Diff, bo);
      end else begin
        e = exp_q.pop_front();
        chk("diff", int'(Diff), int'(e.d));
        chk("bo", int'(bo), int'(e.bo));
        lhs = int'(e.a) - int'(e.b) - int'(e.bin);
        rhs = int'(Diff) - (1 << W) * int'(bo);
        chk("identity", rhs, lhs);
        if (bo === 1'b0) begin
          s = adder(Diff, e.b, e.bin);
          chk("adder_roundtrip", int'(s), int'({1'b0, e.a}));
        end
      end
      prev_d  = Diff;
      prev_bo = bo;
    end else begin
      chk("hold_diff", int'(Diff), int'(prev_d));
      chk("hold_bo", int'(bo), int'(prev_bo));
      prev_d  = Diff;
      prev_bo = bo;
    end
  end

  // One operation; poke>0 re-asserts start with junk operands on that busy cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W-1:0] ed, input logic ebo, input int poke);
    int n;
    exp_t e;
    e.a = a; e.b = b; e.bin = bi; e.d = ed; e.bo = ebo;
    exp_q.push_back(e);
    A = a; B = b; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) n++;
      if (poke > 0 && n == poke) begin
        start = 1'b1; A = ~a; B = a; bin = ~bi;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("busy_cycles", n, W);
  endtask

  initial begin
    int n;
    int e0;
    rst_n = 1'b0; start = 1'b1; A = 4'd9; B = 4'd3; bin = 1'b0;

    // Reset held with start asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_diff", int'(Diff), 0);
      chk("rst_bo", int'(bo), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", int'(busy), 0);

    // Directed vectors.
    do_op(4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 0);
    do_op(4'd5,  4'd7,  1'b0, 4'd14, 1'b1, 0);
    do_op(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 0);
    do_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 0);
    do_op(4'd0,  4'd1,  1'b0, 4'd15, 1'b1, 0);
    do_op(4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 0);
    // start while busy must be ignored.
    do_op(4'd10, 4'd2,  1'b0, 4'd8,  1'b0, 1);
    tick();

    // start held high: three back-to-back ops, A changed during the last one.
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.a = 4'd8; e.b = 4'd1; e.bin = 1'b0; e.d = 4'd7; e.bo = 1'b0;
      exp_q.push_back(e);
    end
    A = 4'd8; B = 4'd1; bin = 1'b0; start = 1'b1;
    tick();
    n = 0;
    do begin tick(); n++; end while (done !== 1'b1 && n < 20);
    chk("b2b_first_latency", n, W);
    n = 0;
    do begin tick(); n++; end while (done !== 1'b1 && n < 20);
    chk("b2b_period", n, W + 1);
    tick();
    start = 1'b0; A = 4'd2;
    n = 1;
    do begin tick(); n++; end while (done !== 1'b1 && n < 20);
    chk("b2b_period2", n, W + 1);
    tick();

    // Reset two cycles into an operation.
    A = 4'd9; B = 4'd5; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(Diff), 0);
    chk("abort_bo", int'(bo), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_idle", int'(busy), 0);
    do_op(4'd4, 4'd4, 1'b0, 4'd0, 1'b0, 0);
    tick();

    // Exhaustive sweep against an arithmetic model.
    e0 = errors;
    for (int bi = 0; bi < 2; bi++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          int t;
          t = a - b - bi;
          if (errors == e0)
            do_op(4'(a), 4'(b), 1'(bi), 4'(t & 15), (t < 0) ? 1'b1 : 1'b0, 0);
        end
      end
    end
    tick();
    tick();
    if (errors == e0) $display("SUCCESS: exhaustive sweep matched");

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
